// File: rtl/table_pkg.sv
// Shared types and default sizing for the predictor-table SRAM controller.
package table_pkg;

    localparam int                  TBL_ADDR_W     = 8;
    localparam int                  TBL_DATA_W     = 4;
    localparam logic [TBL_DATA_W-1:0] TBL_INIT_VAL = 4'b0100;
    localparam int                  TBL_STARVE_LIM = 3;

    typedef enum logic {
        INIT,
        RUN
    } table_state_e;

    // Write-port payload, sized by the package defaults.
    typedef struct packed {
        logic [TBL_ADDR_W-1:0] addr;
        logic [TBL_DATA_W-1:0] data;
        logic [TBL_DATA_W-1:0] mask;
    } wr_req_t;

endpackage

// File: rtl/table_wr_arb.sv
// Two-port write arbiter: port A has fixed priority and port B is forced
// through after STARVE_LIM consecutive losses.
module table_wr_arb
    import table_pkg::*;
#(
    parameter int STARVE_LIM = TBL_STARVE_LIM
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    input  logic a_valid_i,
    input  logic b_valid_i,
    output logic a_grant_o,
    output logic b_grant_o
);

    localparam int CW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    logic [CW-1:0] starve_q, starve_d;
    logic          lim_hit;

    always_comb begin
        lim_hit   = (starve_q == CW'(STARVE_LIM));
        b_grant_o = en_i && b_valid_i && (!a_valid_i || lim_hit);
        a_grant_o = en_i && a_valid_i && !b_grant_o;
        // Any cycle where B is not a losing requester clears its history.
        starve_d  = '0;
        if (en_i && b_valid_i && !b_grant_o) begin
            starve_d = lim_hit ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/table_sram_ctrl.sv
// Predictor-table SRAM controller: init sweep, one read port, two arbitrated
// write ports. Define TABLE_SRAM_CTRL_BYPASS_EN for same-cycle write-to-read merge.
module table_sram_ctrl
    import table_pkg::*;
#(
    parameter int                ADDR_W     = TBL_ADDR_W,
    parameter int                DATA_W     = TBL_DATA_W,
    parameter logic [DATA_W-1:0] INIT_VAL   = TBL_INIT_VAL,
    parameter int                STARVE_LIM = TBL_STARVE_LIM
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    output logic              busy,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_resp_data,
    input  logic              wa_valid,
    output logic              wa_ready,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic [DATA_W-1:0] wa_mask,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] wb_mask,
    output logic [ADDR_W-1:0] sram_r_addr,
    input  logic [DATA_W-1:0] sram_r_data,
    output logic              sram_w_en,
    output logic [ADDR_W-1:0] sram_w_addr,
    output logic [DATA_W-1:0] sram_w_data,
    output logic [DATA_W-1:0] sram_w_mask
);

    table_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_resp_valid_q;
    logic              run_en, wa_gnt, wb_gnt;
    wr_req_t           wa_req, wb_req, wr_sel;

    assign run_en   = reset && (state_q == RUN) && !flush;
    assign rd_ready = reset && (state_q == RUN);
    assign busy     = (state_q == INIT);
    assign wa_ready = wa_gnt;
    assign wb_ready = wb_gnt;

    assign sram_r_addr   = rd_addr;
    assign rd_resp_valid = rd_resp_valid_q;

    table_wr_arb #(
        .STARVE_LIM (STARVE_LIM)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .en_i      (run_en),
        .a_valid_i (wa_valid),
        .b_valid_i (wb_valid),
        .a_grant_o (wa_gnt),
        .b_grant_o (wb_gnt)
    );

    always_comb begin
        wa_req      = '{addr: wa_addr, data: wa_data, mask: wa_mask};
        wb_req      = '{addr: wb_addr, data: wb_data, mask: wb_mask};
        wr_sel      = wb_gnt ? wb_req : wa_req;
        sram_w_en   = wa_gnt || wb_gnt;
        sram_w_addr = wr_sel.addr;
        sram_w_data = wr_sel.data;
        sram_w_mask = wr_sel.mask;
        if (state_q == INIT) begin
            sram_w_en   = reset;
            sram_w_addr = cnt_q;
            sram_w_data = INIT_VAL;
            sram_w_mask = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // Flush wins over everything, including an in-progress sweep.
        if (flush) begin
            state_d = INIT;
            cnt_d   = '0;
        end else if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= INIT;
            cnt_q           <= '0;
            rd_resp_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rd_resp_valid_q <= rd_valid && rd_ready;
        end
    end

`ifdef TABLE_SRAM_CTRL_BYPASS_EN
    logic              byp_hit_q;
    logic [DATA_W-1:0] byp_data_q, byp_mask_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            byp_hit_q <= 1'b0;
        end else begin
            byp_hit_q <= rd_valid && rd_ready && (wa_gnt || wb_gnt) && (rd_addr == wr_sel.addr);
        end
    end

    always_ff @(posedge clock) begin
        byp_data_q <= wr_sel.data;
        byp_mask_q <= wr_sel.mask;
    end

    // The SRAM returns pre-write contents on a collision; patch in the new bits.
    always_comb begin
        rd_resp_data = '0;
        if (rd_resp_valid_q) begin
            rd_resp_data = byp_hit_q ? ((byp_data_q & byp_mask_q) | (sram_r_data & ~byp_mask_q))
                                     : sram_r_data;
        end
    end
`else
    always_comb begin
        rd_resp_data = '0;
        if (rd_resp_valid_q) rd_resp_data = sram_r_data;
    end
`endif

endmodule

// File: tb/tb_table_sram_ctrl.sv
// Scoreboard bench for table_sram_ctrl with a behavioural read-old SRAM model.
module tb_table_sram_ctrl;

    logic       clock = 1'b0;
    logic       reset, flush;
    logic       busy;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_addr;
    logic       rd_resp_valid;
    logic [3:0] rd_resp_data;
    logic       wa_valid, wa_ready;
    logic [7:0] wa_addr;
    logic [3:0] wa_data, wa_mask;
    logic       wb_valid, wb_ready;
    logic [7:0] wb_addr;
    logic [3:0] wb_data, wb_mask;
    logic [7:0] sram_r_addr;
    logic [3:0] sram_r_data;
    logic       sram_w_en;
    logic [7:0] sram_w_addr;
    logic [3:0] sram_w_data, sram_w_mask;

    logic [3:0] mem [0:255];
    logic [3:0] exp_q [$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         bad;

    always #5 clock = ~clock;

    table_sram_ctrl dut (
        .clock(clock), .reset(reset), .flush(flush), .busy(busy),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr),
        .wa_data(wa_data), .wa_mask(wa_mask),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_mask(wb_mask),
        .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
        .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr),
        .sram_w_data(sram_w_data), .sram_w_mask(sram_w_mask)
    );

    // SRAM model: registered read returning pre-write contents, masked write.
    always @(posedge clock) begin
        sram_r_data <= mem[sram_r_addr];
        if (sram_w_en)
            mem[sram_w_addr] <= (sram_w_data & sram_w_mask) | (mem[sram_w_addr] & ~sram_w_mask);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented response must match the oldest expectation.
    always @(negedge clock) begin
        if (rd_resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_resp_unexpected: got data %0h, required no response", rd_resp_data);
            end else begin
                chk("rd_resp_data", rd_resp_data, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [3:0] e);
        rd_valid = 1'b1;
        rd_addr  = a;
        #1;
        chk("rd_ready", rd_ready, 1);
        exp_q.push_back(e);
        step();
        rd_valid = 1'b0;
    endtask

    task automatic wr_a(input logic [7:0] a, input logic [3:0] d, input logic [3:0] m);
        wa_valid = 1'b1;
        wa_addr  = a;
        wa_data  = d;
        wa_mask  = m;
        #1;
        chk("wa_ready", wa_ready, 1);
        chk("wr_sram_addr", {sram_w_en, sram_w_addr}, {1'b1, a});
        step();
        wa_valid = 1'b0;
    endtask

    task automatic sweep(input int n, output int nbad);
        nbad = 0;
        for (int k = 0; k < n; k++) begin
            #1;
            if (busy !== 1'b1 || sram_w_en !== 1'b1 || sram_w_addr !== 8'(k) ||
                sram_w_data !== 4'b0100 || sram_w_mask !== 4'hF ||
                rd_ready !== 1'b0 || wa_ready !== 1'b0 || wb_ready !== 1'b0)
                nbad++;
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 4'hE;
        reset = 1'b0; flush = 1'b0;
        rd_valid = 1'b1; rd_addr = 8'h33;
        wa_valid = 1'b1; wa_addr = 8'h01; wa_data = 4'h1; wa_mask = 4'hF;
        wb_valid = 1'b1; wb_addr = 8'h02; wb_data = 4'h2; wb_mask = 4'hF;
        repeat (3) step();
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_rd_resp_valid", rd_resp_valid, 0);
        chk("rst_rd_resp_data", rd_resp_data, 0);
        chk("rst_sram_w_en", sram_w_en, 0);
        chk("rst_readies", {rd_ready, wa_ready, wb_ready}, 0);

        // Release reset with a read held pending; nothing may be accepted during the sweep.
        reset = 1'b1;
        wa_valid = 1'b0; wb_valid = 1'b0;
        sweep(256, bad);
        chk("init_sweep_bad_cycles", bad, 0);
        rd_valid = 1'b0;
        #1;
        chk("run_busy", busy, 0);
        chk("run_rd_ready", rd_ready, 1);

        rd(8'h00, 4'b0100);
        rd(8'h7F, 4'b0100);
        rd(8'hFF, 4'b0100);

        wr_a(8'h12, 4'hA, 4'hF);
        rd(8'h12, 4'hA);
        wr_a(8'h12, 4'h5, 4'h3);
        rd(8'h12, 4'h9);

        // Both writers valid: A, A, A, B repeating.
        wa_valid = 1'b1; wa_addr = 8'h20; wa_data = 4'h1; wa_mask = 4'hF;
        wb_valid = 1'b1; wb_addr = 8'h21; wb_data = 4'h2; wb_mask = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("arb_wb_ready", wb_ready, (i % 4) == 3);
            chk("arb_wa_ready", wa_ready, (i % 4) != 3);
            step();
        end
        wa_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("arb_b_alone", {wa_ready, wb_ready}, 2'b01);
            step();
        end
        wb_valid = 1'b0;
        #1;
        chk("arb_idle", {wa_ready, wb_ready}, 2'b00);
        rd(8'h20, 4'h1);
        rd(8'h21, 4'h2);

        // Same-cycle read and write to one address.
        wr_a(8'h40, 4'h1, 4'hF);
        wa_valid = 1'b1; wa_addr = 8'h40; wa_data = 4'hC; wa_mask = 4'hF;
        rd_valid = 1'b1; rd_addr = 8'h40;
`ifdef TABLE_SRAM_CTRL_BYPASS_EN
        exp_q.push_back(4'hC);
`else
        exp_q.push_back(4'h1);
`endif
        #1;
        chk("rw_same_wa_ready", wa_ready, 1);
        chk("rw_same_rd_ready", rd_ready, 1);
        step();
        wa_valid = 1'b0; rd_valid = 1'b0;
        rd(8'h40, 4'hC);

        // Flush in RUN with a write and a read in the same cycle.
        wa_valid = 1'b1; wa_addr = 8'h55; wa_data = 4'h7; wa_mask = 4'hF;
        rd_valid = 1'b1; rd_addr = 8'h12;
        flush = 1'b1;
        #1;
        chk("flush_wa_ready", wa_ready, 0);
        chk("flush_sram_w_en", sram_w_en, 0);
        chk("flush_rd_ready", rd_ready, 1);
        exp_q.push_back(4'h9);
        step();
        flush = 1'b0; rd_valid = 1'b0;
        sweep(128, bad);
        chk("flush_sweep_first_half", bad, 0);
        #1;
        chk("midsweep_addr", sram_w_addr, 8'h80);
        flush = 1'b1;
        step();
        flush = 1'b0;
        sweep(256, bad);
        chk("flush_restart_sweep", bad, 0);
        #1;
        chk("post_flush_busy", busy, 0);
        chk("post_flush_wa_ready", wa_ready, 1);
        step();
        wa_valid = 1'b0;
        rd(8'h55, 4'h7);
        rd(8'h40, 4'b0100);
        rd(8'h12, 4'b0100);

        // Reset asserted while a read response is in flight.
        rd_valid = 1'b1; rd_addr = 8'h55;
        wa_valid = 1'b1; wa_addr = 8'h60; wa_data = 4'h3; wa_mask = 4'hF;
        #1;
        chk("pre_rst_wa_ready", wa_ready, 1);
        exp_q.push_back(4'h7);
        step();
        rd_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_w_en", {sram_w_en, wa_ready, rd_ready}, 0);
        step();
        #1;
        chk("mid_rst_rd_resp_valid", rd_resp_valid, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_sram_w_en", sram_w_en, 0);
        reset = 1'b1;
        wa_valid = 1'b0;
        sweep(4, bad);
        chk("rst_sweep_restart", bad, 0);
        step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
